dp_issue: RTL and testbench

//  Decode/issue stage that feeds the ALU. Accepts 32-bit ARM data-processing instructions over a valid/ready handshake.

---
 rtl/dp_issue_pkg.sv | 18 +
 rtl/dp_cond_check.sv | 37 +++
 rtl/dp_issue.sv | 108 ++++++++++
 tb/tb_dp_issue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_issue_pkg.sv
// dp_issue_pkg: opcode and condition encodings, flag bit positions shared by the issue stage
package dp_issue_pkg;
  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } op_t;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_t;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;
  function automatic logic is_test(input op_t op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction
endpackage

// File: rtl/dp_cond_check.sv
// dp_cond_check: ARM condition field evaluated against {N,Z,C,V}
//   i_cond : instr[31:28]
//   i_nzcv : current flags
//   o_pass : instruction executes
module dp_cond_check
  import dp_issue_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign w_n = i_nzcv[N_BIT];
  assign w_z = i_nzcv[Z_BIT];
  assign w_c = i_nzcv[C_BIT];
  assign w_v = i_nzcv[V_BIT];
  always_comb begin
    case (cond_t'(i_cond))
      C_EQ:    o_pass = w_z;
      C_NE:    o_pass = !w_z;
      C_CS:    o_pass = w_c;
      C_CC:    o_pass = !w_c;
      C_MI:    o_pass = w_n;
      C_PL:    o_pass = !w_n;
      C_VS:    o_pass = w_v;
      C_VC:    o_pass = !w_v;
      C_HI:    o_pass = w_c & !w_z;
      C_LS:    o_pass = !w_c | w_z;
      C_GE:    o_pass = w_n == w_v;
      C_LT:    o_pass = w_n != w_v;
      C_GT:    o_pass = !w_z & (w_n == w_v);
      C_LE:    o_pass = w_z | (w_n != w_v);
      C_AL:    o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_issue.sv
// dp_issue: decode/issue stage for ARM data-processing instructions feeding a combinational ALU
//   instr_valid/instr/instr_ready : instruction handshake (D)
//   rn_addr/rm_addr, rn_data/rm_data : register-file read port (combinational)
//   operand_a/operand_b/alu_control/alu_valid : registered ALU inputs (E)
//   result/nzcv/result_writeback/nzcv_writeback : ALU outputs
//   rd_we/rd_addr/rd_data : register-file write port (W)
//   nzcv_q : CPSR flags, illegal : pulse when an unsupported encoding is dropped
module dp_issue
  import dp_issue_pkg::*;
#(
  parameter logic [3:0] RESET_NZCV   = 4'b0000,
  parameter bit         DROP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [3:0]  alu_control,
  output logic        alu_valid,
  input  logic [31:0] result,
  input  logic [3:0]  nzcv,
  input  logic        result_writeback,
  input  logic        nzcv_writeback,
  output logic        rd_we,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [3:0]  nzcv_q,
  output logic        illegal
);
  op_t         w_op, r_op;
  logic        w_sup, w_use_rn, w_use_rm, w_pass, w_e_wr, w_e_fl, w_haz, w_acc, w_issue;
  logic [4:0]  w_sh;
  logic [31:0] w_imm, w_rot, r_opa, r_opb, r_rd_data;
  logic [3:0]  r_rd, r_rd_addr, r_nzcv;
  logic        r_s, r_alu_valid, r_rd_we, r_illegal;
  assign w_op     = op_t'(instr[24:21]);
  assign w_sup    = instr[27:26] == 2'b00 && (instr[25] || instr[11:4] == 8'h00);
  assign w_use_rn = !(w_op inside {OP_MOV, OP_MVN});
  assign w_use_rm = !instr[25];
  assign rn_addr  = instr[19:16];
  assign rm_addr  = instr[3:0];
  // rotate right by 2*rot; a zero shift makes the left term vanish
  assign w_imm = {24'h0, instr[7:0]};
  assign w_sh  = {instr[11:8], 1'b0};
  assign w_rot = (w_imm >> w_sh) | (w_imm << (6'd32 - {1'b0, w_sh}));
  dp_cond_check u_cond (
    .i_cond (instr[31:28]),
    .i_nzcv (r_nzcv),
    .o_pass (w_pass)
  );
  assign w_e_wr = r_alu_valid & result_writeback;
  assign w_e_fl = r_alu_valid & nzcv_writeback & (r_s | is_test(r_op));
  // no forwarding: any source still in flight in E or W stalls, as does a conditional behind a flag writer
  assign w_haz = w_sup & (
      (w_e_wr  & ((w_use_rn & r_rd == rn_addr)      | (w_use_rm & r_rd == rm_addr))) |
      (r_rd_we & ((w_use_rn & r_rd_addr == rn_addr) | (w_use_rm & r_rd_addr == rm_addr))) |
      (w_e_fl  & cond_t'(instr[31:28]) != C_AL));
  assign instr_ready = !reset & !w_haz & (DROP_ILLEGAL | w_sup);
  assign w_acc       = instr_valid & instr_ready;
  assign w_issue     = w_acc & w_sup & w_pass;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_valid <= 1'b0;
      r_rd_we     <= 1'b0;
      r_illegal   <= 1'b0;
      r_nzcv      <= RESET_NZCV;
      r_opa       <= '0;
      r_opb       <= '0;
      r_op        <= OP_AND;
      r_s         <= 1'b0;
      r_rd        <= '0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
    end else begin
      r_alu_valid <= w_issue;
      r_illegal   <= w_acc & !w_sup;
      r_rd_we     <= r_alu_valid & result_writeback;
      if (w_issue) begin
        r_opa <= rn_data;
        r_opb <= instr[25] ? w_rot : rm_data;
        r_op  <= w_op;
        r_s   <= instr[20];
        r_rd  <= instr[15:12];
      end
      if (r_alu_valid) begin
        r_rd_addr <= r_rd;
        r_rd_data <= result;
      end
      if (w_e_fl) r_nzcv <= nzcv;
    end
  end
  assign operand_a   = r_opa;
  assign operand_b   = r_opb;
  assign alu_control = r_op;
  assign alu_valid   = r_alu_valid;
  assign rd_we       = r_rd_we;
  assign rd_addr     = r_rd_addr;
  assign rd_data     = r_rd_data;
  assign nzcv_q      = r_nzcv;
  assign illegal     = r_illegal;
endmodule

// File: tb/tb_dp_issue.sv
// tb_dp_issue: randomized and directed checks of dp_issue against a sequential ISA-level model
module tb_dp_issue;
  localparam int DEPTH = 8192;
  logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready, alu_valid, result_writeback, nzcv_writeback, rd_we, illegal;
  logic [3:0]  rn_addr, rm_addr, alu_control, nzcv, rd_addr, nzcv_q;
  logic [31:0] rn_data, rm_data, operand_a, operand_b, result, rd_data;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  dp_issue #(.RESET_NZCV(4'b0000), .DROP_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rn_data(rn_data), .rm_data(rm_data),
    .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control), .alu_valid(alu_valid),
    .result(result), .nzcv(nzcv), .result_writeback(result_writeback), .nzcv_writeback(nzcv_writeback),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .nzcv_q(nzcv_q), .illegal(illegal)
  );

  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    logic [31:0] x, y, r;
    logic [32:0] s;
    logic ci, ar, c, v;
    x = a; y = b; ci = 1'b0; ar = 1'b1; r = '0; c = f[1]; v = f[0];
    case (op)
      4'd2, 4'd10: begin y = ~b; ci = 1'b1; end
      4'd3:        begin x = b; y = ~a; ci = 1'b1; end
      4'd4, 4'd11: begin end
      4'd5:        ci = f[1];
      4'd6:        begin y = ~b; ci = f[1]; end
      4'd7:        begin x = b; y = ~a; ci = f[1]; end
      default:     ar = 1'b0;
    endcase
    s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    if (ar) begin
      r = s[31:0]; c = s[32]; v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (op)
        4'd0, 4'd8: r = a & b;
        4'd1, 4'd9: r = a ^ b;
        4'd12:      r = a | b;
        4'd13:      r = b;
        4'd14:      r = a & ~b;
        default:    r = ~b;
      endcase
    end
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  // external ALU and register file around the DUT
  logic [31:0] rf [16];
  assign rn_data = rf[rn_addr];
  assign rm_data = rf[rm_addr];
  assign {nzcv, result} = alu_f(alu_control, operand_a, operand_b, nzcv_q);
  assign result_writeback = alu_control[3:2] != 2'b10;
  assign nzcv_writeback = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) for (int i = 0; i < 16; i++) rf[i] <= 32'(i * 3 + 5);
    else if (rd_we) rf[rd_addr] <= rd_data;
  end

  // sequential ISA model: architectural registers/flags plus per-cycle expected outputs
  logic [31:0] mreg [16];
  logic [3:0]  mflags, cur_nz;
  int          last_wr [16];
  int          last_fl;
  bit          exp_av [DEPTH], exp_chka [DEPTH], exp_we [DEPTH], exp_ill [DEPTH], exp_nzv [DEPTH];
  logic [31:0] exp_a [DEPTH], exp_b [DEPTH], exp_rdat [DEPTH];
  logic [3:0]  exp_op [DEPTH], exp_rd [DEPTH], exp_nz [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] w);
    return w[27:26] == 2'b00 && (w[25] || w[11:4] == 8'h00);
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0: return z;            4'd1: return !z;
      4'd2: return cc;           4'd3: return !cc;
      4'd4: return n;            4'd5: return !n;
      4'd6: return v;            4'd7: return !v;
      4'd8: return cc && !z;     4'd9: return !cc || z;
      4'd10: return n == v;      4'd11: return n != v;
      4'd12: return !z && n == v; 4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    repeat (n) v = {v[0], v[31:1]};
    return v;
  endfunction

  function automatic bit model_ready(input logic [31:0] w, input int d);
    bit use_rn;
    if (!legal(w)) return 1'b1;
    use_rn = w[24:21] != 4'd13 && w[24:21] != 4'd15;
    if (use_rn && d < last_wr[w[19:16]] + 3) return 1'b0;
    if (!w[25] && d < last_wr[w[3:0]] + 3) return 1'b0;
    if (w[31:28] != 4'he && d < last_fl + 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_accept(input logic [31:0] w, input int d);
    logic [31:0] a, b;
    logic [35:0] fr;
    logic [3:0]  op;
    if (!legal(w)) begin
      exp_ill[d + 1] = 1'b1;
      return;
    end
    if (!cond_ok(w[31:28], mflags)) return;
    op = w[24:21];
    a = mreg[w[19:16]];
    b = w[25] ? ror({24'h0, w[7:0]}, 2 * int'(w[11:8])) : mreg[w[3:0]];
    exp_av[d + 1] = 1'b1; exp_a[d + 1] = a; exp_b[d + 1] = b; exp_op[d + 1] = op;
    exp_chka[d + 1] = op != 4'd13 && op != 4'd15;
    fr = alu_f(op, a, b, mflags);
    if (op[3:2] != 2'b10) begin
      mreg[w[15:12]] = fr[31:0];
      last_wr[w[15:12]] = d;
      exp_we[d + 2] = 1'b1; exp_rd[d + 2] = w[15:12]; exp_rdat[d + 2] = fr[31:0];
    end
    if (w[20] || op[3:2] == 2'b10) begin
      mflags = fr[35:32];
      last_fl = d;
      exp_nzv[d + 2] = 1'b1; exp_nz[d + 2] = fr[35:32];
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mreg[i] = 32'(i * 3 + 5);
        last_wr[i] = -10;
      end
      mflags = 4'b0000; cur_nz = 4'b0000; last_fl = -10;
      for (int k = 0; k < 4; k++) begin
        exp_av[cyc + k] = 0; exp_we[cyc + k] = 0; exp_ill[cyc + k] = 0; exp_nzv[cyc + k] = 0;
      end
    end else begin
      if (exp_nzv[cyc]) cur_nz = exp_nz[cyc];
      chk("alu_valid", 32'(alu_valid), 32'(exp_av[cyc]));
      if (exp_av[cyc]) begin
        chk("alu_control", 32'(alu_control), 32'(exp_op[cyc]));
        chk("operand_b", operand_b, exp_b[cyc]);
        if (exp_chka[cyc]) chk("operand_a", operand_a, exp_a[cyc]);
      end
      chk("rd_we", 32'(rd_we), 32'(exp_we[cyc]));
      if (exp_we[cyc]) begin
        chk("rd_addr", 32'(rd_addr), 32'(exp_rd[cyc]));
        chk("rd_data", rd_data, exp_rdat[cyc]);
      end
      chk("illegal", 32'(illegal), 32'(exp_ill[cyc]));
      chk("nzcv_q", 32'(nzcv_q), 32'(cur_nz));
      if (instr_valid) begin
        chk("instr_ready", 32'(instr_ready), 32'(model_ready(instr, cyc)));
        if (instr_ready) model_accept(instr, cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w, output int stalls);
    stalls = 0;
    instr_valid = 1'b1;
    instr = w;
    @(negedge clk);
    while (!instr_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: instr %h not accepted within 20 cycles", w);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic        i;
    i = 1'($urandom);
    w[31:28] = $urandom_range(0, 15) < 9 ? 4'he : 4'($urandom_range(0, 15));
    w[27:26] = 2'b00;
    w[25]    = i;
    w[24:21] = 4'($urandom);
    w[20]    = 1'($urandom);
    w[19:16] = 4'($urandom_range(0, 7));
    w[15:12] = 4'($urandom_range(0, 7));
    w[11:0]  = i ? 12'($urandom) : {8'h00, 4'($urandom_range(0, 7))};
    case ($urandom_range(0, 19))
      0: w[27:26] = 2'($urandom_range(1, 3));
      1: if (!i) w[11:4] = 8'($urandom_range(1, 255));
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int s;
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = 32'hE3A014FF;
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready", 32'(instr_ready), 32'd0);
      chk("reset_alu_valid", 32'(alu_valid), 32'd0);
      chk("reset_rd_we", 32'(rd_we), 32'd0);
      chk("reset_nzcv", 32'(nzcv_q), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    instr_valid = 1'b0;
    idle(2);
    // MOV r1,#0xFF ror 8
    issue(32'hE3A014FF, s);
    @(negedge clk);
    chk("mov_operand_b", operand_b, 32'hFF000000);
    chk("mov_alu_control", 32'(alu_control), 32'd13);
    @(negedge clk);
    chk("mov_rd_we", 32'(rd_we), 32'd1);
    chk("mov_rd_addr", 32'(rd_addr), 32'd1);
    chk("mov_rd_data", rd_data, 32'hFF000000);
    idle(3);
    // ADD r1,r0,#1 ; ADD r2,r1,#1
    issue(32'hE2801001, s);
    issue(32'hE2812001, s);
    chk("raw_stall", 32'(s), 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("raw_rd_addr", 32'(rd_addr), 32'd2);
    chk("raw_rd_data", rd_data, 32'd7);
    idle(3);
    // SUBS r2,r0,r0 ; ADDEQ r3,r0,#1
    issue(32'hE0502000, s);
    issue(32'h02803001, s);
    chk("flag_stall", 32'(s), 32'd1);
    @(negedge clk);
    chk("subs_nzcv", 32'(nzcv_q), 32'b0110);
    chk("addeq_valid", 32'(alu_valid), 32'd1);
    @(negedge clk);
    chk("addeq_rd_addr", 32'(rd_addr), 32'd3);
    chk("addeq_rd_data", rd_data, 32'd6);
    idle(3);
    // CMP r0,#5 ; ADDNE r4,r0,#1
    issue(32'hE3500005, s);
    issue(32'h12804001, s);
    chk("cmp_stall", 32'(s), 32'd1);
    @(negedge clk);
    chk("addne_no_valid", 32'(alu_valid), 32'd0);
    chk("cmp_nzcv", 32'(nzcv_q), 32'b0110);
    idle(3);
    // LDR encoding is dropped
    issue(32'hE5901000, s);
    chk("ldr_no_stall", 32'(s), 32'd0);
    @(negedge clk);
    chk("ldr_illegal", 32'(illegal), 32'd1);
    chk("ldr_no_valid", 32'(alu_valid), 32'd0);
    @(negedge clk);
    chk("ldr_illegal_end", 32'(illegal), 32'd0);
    chk("ldr_no_rd_we", 32'(rd_we), 32'd0);
    issue(32'hE3A05003, s);
    @(negedge clk);
    chk("post_ldr_valid", 32'(alu_valid), 32'd1);
    @(negedge clk);
    chk("post_ldr_rd_addr", 32'(rd_addr), 32'd5);
    chk("post_ldr_rd_data", rd_data, 32'd3);
    idle(3);
    for (int n = 0; n < 800 && cyc < DEPTH - 1000; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) idle(gap);
      issue(rnd_instr(), s);
    end
    idle(5);
    // reset with an instruction in E discards it
    issue(32'hE2806001, s);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_alu_valid", 32'(alu_valid), 32'd0);
    chk("midreset_rd_we", 32'(rd_we), 32'd0);
    chk("midreset_illegal", 32'(illegal), 32'd0);
    chk("midreset_nzcv", 32'(nzcv_q), 32'd0);
    chk("midreset_ready", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
